// File: rtl/bias_add_s_if.sv
// Stream bundle for bias_add_s: two FWFT ap_fifo read sides (bias, acc) and one ap_fifo write side.
// The block sits on the slave side; whatever feeds the fifos and drains the output uses master.
interface bias_add_s_if #(
    parameter int COEFF_WIDTH = 16,
    parameter int ACC_WIDTH   = 32
);
    logic [COEFF_WIDTH-1:0] bias_V_dout;
    logic                   bias_V_empty_n;
    logic                   bias_V_read;
    logic [ACC_WIDTH-1:0]   acc_V_dout;
    logic                   acc_V_empty_n;
    logic                   acc_V_read;
    logic [ACC_WIDTH-1:0]   output_V_din;
    logic                   output_V_full_n;
    logic                   output_V_write;

    modport master (
        output bias_V_dout,
        output bias_V_empty_n,
        input  bias_V_read,
        output acc_V_dout,
        output acc_V_empty_n,
        input  acc_V_read,
        input  output_V_din,
        output output_V_full_n,
        input  output_V_write
    );

    modport slave (
        input  bias_V_dout,
        input  bias_V_empty_n,
        output bias_V_read,
        input  acc_V_dout,
        input  acc_V_empty_n,
        output acc_V_read,
        output output_V_din,
        input  output_V_full_n,
        output output_V_write
    );
endinterface

// File: rtl/bias_add_s.sv
// Per-channel bias add with saturation: loads NUM_CH bias words into a local bank, then adds
// bank[ch] to every accumulator word of a NUM_PIX-pixel frame before reloading for the next frame.
module bias_add_s #(
    parameter int COEFF_WIDTH = 16,
    parameter int ACC_WIDTH   = 32,
    parameter int NUM_CH      = 32,
    parameter int NUM_PIX     = 64
) (
    input  logic        ap_clk,
    input  logic        ap_rst,
    bias_add_s_if.slave s
);
    localparam int CH_W  = (NUM_CH  > 1) ? $clog2(NUM_CH)  : 1;
    localparam int PIX_W = (NUM_PIX > 1) ? $clog2(NUM_PIX) : 1;
    localparam logic [CH_W-1:0]      CH_LAST  = CH_W'(NUM_CH - 1);
    localparam logic [PIX_W-1:0]     PIX_LAST = PIX_W'(NUM_PIX - 1);
    localparam logic [ACC_WIDTH-1:0] SAT_MAX  = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] SAT_MIN  = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    typedef enum logic {
        LOAD,
        RUN
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [CH_W-1:0]        r_ch_cnt;
    logic [CH_W-1:0]        w_ch_cnt_nxt;
    logic [PIX_W-1:0]       r_pix_cnt;
    logic [PIX_W-1:0]       w_pix_cnt_nxt;
    logic                   r_out_valid;
    logic                   w_out_valid_nxt;
    logic [ACC_WIDTH-1:0]   r_out_data;
    logic [ACC_WIDTH-1:0]   w_out_data_nxt;
    logic [COEFF_WIDTH-1:0] r_bank [NUM_CH];

    logic                   w_bias_read;
    logic                   w_acc_read;
    logic                   w_adv;
    logic                   w_out_accept;
    logic [COEFF_WIDTH-1:0] w_bias;
    logic [ACC_WIDTH:0]     w_sum;
    logic [ACC_WIDTH-1:0]   w_sat;

    // One guard bit is enough: the two top sum bits disagree exactly when the result overflowed.
    assign w_bias = r_bank[r_ch_cnt];
    assign w_sum  = {s.acc_V_dout[ACC_WIDTH-1], s.acc_V_dout}
                  + {{(ACC_WIDTH+1-COEFF_WIDTH){w_bias[COEFF_WIDTH-1]}}, w_bias};

    always_comb begin
        w_sat = w_sum[ACC_WIDTH-1:0];
        if (w_sum[ACC_WIDTH] != w_sum[ACC_WIDTH-1]) begin
            w_sat = w_sum[ACC_WIDTH] ? SAT_MIN : SAT_MAX;
        end
    end

    // The output register drains in either state, so a frame's last word can leave during reload.
    always_comb begin
        w_state_nxt     = r_state;
        w_ch_cnt_nxt    = r_ch_cnt;
        w_pix_cnt_nxt   = r_pix_cnt;
        w_out_valid_nxt = r_out_valid;
        w_out_data_nxt  = r_out_data;
        w_bias_read     = 1'b0;
        w_acc_read      = 1'b0;
        w_out_accept    = r_out_valid & s.output_V_full_n;
        w_adv           = ~r_out_valid | s.output_V_full_n;

        if (w_out_accept) begin
            w_out_valid_nxt = 1'b0;
        end

        case (r_state)
            LOAD: begin
                w_bias_read = s.bias_V_empty_n & ~ap_rst;
                if (w_bias_read) begin
                    if (r_ch_cnt == CH_LAST) begin
                        w_ch_cnt_nxt = '0;
                        w_state_nxt  = RUN;
                    end else begin
                        w_ch_cnt_nxt = r_ch_cnt + 1'b1;
                    end
                end
            end
            RUN: begin
                w_acc_read = s.acc_V_empty_n & w_adv & ~ap_rst;
                if (w_acc_read) begin
                    w_out_data_nxt  = w_sat;
                    w_out_valid_nxt = 1'b1;
                    if (r_ch_cnt == CH_LAST) begin
                        w_ch_cnt_nxt = '0;
                        if (r_pix_cnt == PIX_LAST) begin
                            w_pix_cnt_nxt = '0;
                            w_state_nxt   = LOAD;
                        end else begin
                            w_pix_cnt_nxt = r_pix_cnt + 1'b1;
                        end
                    end else begin
                        w_ch_cnt_nxt = r_ch_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = LOAD;
            end
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_state     <= LOAD;
            r_ch_cnt    <= '0;
            r_pix_cnt   <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_ch_cnt    <= w_ch_cnt_nxt;
            r_pix_cnt   <= w_pix_cnt_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_data  <= w_out_data_nxt;
        end
    end

    // The bank needs no reset: every entry is rewritten before RUN reads it.
    always_ff @(posedge ap_clk) begin
        if (w_bias_read) begin
            r_bank[r_ch_cnt] <= s.bias_V_dout;
        end
    end

    assign s.bias_V_read    = w_bias_read;
    assign s.acc_V_read     = w_acc_read;
    assign s.output_V_write = r_out_valid & ~ap_rst;
    assign s.output_V_din   = r_out_data;
endmodule
